// File: rtl/all_pkgs.sv
// rtl/all_pkgs.sv - shared widths, fetch entry type and PC step for the fetch path
package all_pkgs;

  localparam int WIDTH   = 32;
  localparam int PC_STEP = 4;

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry instruction queue with synchronous clear
module fetch_fifo
  import all_pkgs::*;
#(
  parameter int DW    = $bits(fetch_entry_t),
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // A push into a full queue is legal only when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/fetch_queue_stage.sv
// rtl/fetch_queue_stage.sv - credit-based pipelined instruction fetch feeding a decode queue
module fetch_queue_stage
  import all_pkgs::*;
#(
  parameter int                WIDTH           = all_pkgs::WIDTH,
  parameter int                DEPTH           = 4,
  parameter int                MAX_OUTSTANDING = 2,
  parameter logic [WIDTH-1:0]  RESET_PC        = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] flush_pc,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] instr_out
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
  logic [WIDTH-1:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0]      outst_q, outst_d;
  logic [CW-1:0]      discard_q, discard_d;

  logic [CW-1:0]      fifo_count;
  logic               fifo_empty, fifo_full;
  logic [2*WIDTH-1:0] head;
  logic [CW:0]        in_use;
  logic               fire, rv_ok, keep;

  // Slots already promised (queued + in flight) bound new requests so a kept response always fits.
  assign in_use   = {1'b0, fifo_count} + {1'b0, outst_q};
  assign imem_req = !rst && !flush && !fifo_full
                    && (outst_q < CW'(MAX_OUTSTANDING))
                    && (in_use < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc_q;

  assign fire  = imem_req && imem_gnt;
  assign rv_ok = imem_rvalid && (outst_q != '0);
  assign keep  = rv_ok && !flush && (discard_q == '0);

  always_comb begin
    outst_d    = outst_q + CW'(fire) - CW'(rv_ok);
    discard_d  = discard_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    if (flush) begin
      // Everything still in flight belongs to the old path, minus a response retiring right now.
      discard_d  = outst_q - CW'(rv_ok);
      fetch_pc_d = flush_pc;
      resp_pc_d  = flush_pc;
    end else begin
      if (rv_ok && (discard_q != '0)) discard_d = discard_q - CW'(1);
      if (fire) fetch_pc_d = fetch_pc_q + WIDTH'(PC_STEP);
      if (keep) resp_pc_d  = resp_pc_q + WIDTH'(PC_STEP);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
    end
  end

  fetch_fifo #(
    .DW    (2 * WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (keep),
    .push_data ({resp_pc_q, imem_rdata}),
    .pop       (instr_valid && instr_ready),
    .pop_data  (head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign instr_valid = !fifo_empty && !flush;
  assign pc_out      = instr_valid ? head[2*WIDTH-1:WIDTH] : '0;
  assign instr_out   = instr_valid ? head[WIDTH-1:0]       : '0;

endmodule

// File: tb/tb_fetch_queue_stage.sv
// tb/tb_fetch_queue_stage.sv - scoreboard bench for fetch_queue_stage
module tb_fetch_queue_stage;

  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic        clk = 0;
  logic        rst = 1;
  logic        flush = 0;
  logic [31:0] flush_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 0;
  logic        imem_rvalid = 0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic        instr_ready = 0;
  logic [31:0] pc_out;
  logic [31:0] instr_out;

  fetch_queue_stage #(
    .WIDTH(32), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .flush_pc(flush_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc_out(pc_out), .instr_out(instr_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } req_t;

  req_t        inflight[$];
  logic [63:0] exp_q[$];
  logic [31:0] exp_fetch = 32'h0;
  logic [31:0] first_pc = 32'h0;
  bit          first_pending = 0;
  bit          last_flushed = 0;
  int          cyc = 0;
  int          n_total = 0;
  int          n_bad = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // fmode: 0 none, 1 flush now, 2 flush only when a response arrives while entries are queued
  task automatic cycle(input int fmode, input logic [31:0] fpc, input logic rdy,
                       input int gprob, input int lat_lo, input int lat_hi, input bit stray);
    bit          resp, do_flush, exp_req, g;
    req_t        r;
    logic [63:0] e;
    @(posedge clk); #1;
    cyc++;
    resp     = (inflight.size() > 0) && (inflight[0].due <= cyc);
    do_flush = (fmode == 1) || (fmode == 2 && resp && exp_q.size() > 0);
    last_flushed = do_flush;
    flush       = do_flush;
    flush_pc    = fpc;
    instr_ready = rdy;
    imem_rvalid = resp || stray;
    imem_rdata  = resp ? mem_word(inflight[0].addr) : (stray ? 32'hBAD0_BAD0 : 32'h0);
    imem_gnt    = 0;
    assert (!(imem_rvalid && inflight.size() == 0) || stray);
    #1;
    exp_req = !do_flush && (inflight.size() < MAXO) && (exp_q.size() + inflight.size() < DEPTH);
    check("req", imem_req, exp_req);
    check("valid", instr_valid, (exp_q.size() > 0) && !do_flush);
    if (!instr_valid) check("idle_zero", {pc_out, instr_out}, 64'h0);
    if (instr_valid && rdy && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("pc", pc_out, e[63:32]);
      check("instr", instr_out, e[31:0]);
      if (first_pending) begin
        check("first_pc", pc_out, first_pc);
        first_pending = 0;
      end
    end
    if (resp) begin
      r = inflight.pop_front();
      if (!do_flush && !r.stale) exp_q.push_back({r.addr, mem_word(r.addr)});
    end
    g = ($urandom_range(99) < gprob);
    imem_gnt = g;
    if (imem_req && g) begin
      check("addr", imem_addr, exp_fetch);
      r.addr  = exp_fetch;
      r.due   = cyc + $urandom_range(lat_hi, lat_lo);
      r.stale = 0;
      inflight.push_back(r);
      exp_fetch += 32'd4;
      check("outstanding_le_max", inflight.size() <= MAXO, 1);
    end
    if (do_flush) begin
      exp_q.delete();
      foreach (inflight[i]) inflight[i].stale = 1;
      exp_fetch     = fpc;
      first_pc      = fpc;
      first_pending = 1;
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", instr_valid, 0);
    check("rst_pc", pc_out, 32'h0);
    check("rst_instr", instr_out, 32'h0);
  endtask

  initial begin
    bit hit;
    #3;
    check_reset_outputs();
    @(posedge clk); #2;
    rst = 0;

    // steady stream, single-cycle memory
    repeat (20) cycle(0, 0, 1, 100, 1, 1, 0);

    // decode stalls: queue fills, requests stop, then drains in order
    repeat (12) cycle(0, 0, 0, 100, 1, 1, 0);
    check("stall_full", exp_q.size(), DEPTH);
    repeat (12) cycle(0, 0, 1, 100, 1, 1, 0);

    // random grant / latency / ready
    repeat (300) cycle(0, 0, 1'($urandom_range(1)), 60, 1, 5, 0);

    // flush with requests in flight and entries queued
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      cycle(0, 0, 0, 100, 3, 3, 0);
      hit = (exp_q.size() >= 2) && (inflight.size() >= 1);
    end
    check("flush_setup", hit, 1);
    cycle(1, 32'h100, 0, 100, 3, 3, 0);
    repeat (20) cycle(0, 0, 1, 100, 1, 1, 0);
    check("first_after_flush_seen", first_pending, 0);

    // flush on the same cycle as a pop and an arriving response
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      cycle(2, 32'h200, 1, 100, 1, 2, 0);
      hit = last_flushed;
    end
    check("flush_pop_rvalid_hit", hit, 1);
    repeat (15) cycle(0, 0, 1, 100, 1, 2, 0);
    check("first_after_flush2_seen", first_pending, 0);

    // back-to-back flushes: last target wins
    repeat (6) cycle(0, 0, 0, 100, 2, 4, 0);
    cycle(1, 32'h300, 0, 100, 2, 4, 0);
    cycle(1, 32'h400, 0, 100, 2, 4, 0);
    repeat (20) cycle(0, 0, 1, 100, 1, 3, 0);
    check("first_after_double_flush_seen", first_pending, 0);

    // reset in the middle of a burst
    repeat (10) cycle(0, 0, 1, 100, 3, 5, 0);
    @(posedge clk); #3;
    rst = 1;
    flush = 0; imem_gnt = 0; imem_rvalid = 0; instr_ready = 0;
    #1;
    check_reset_outputs();
    inflight.delete();
    exp_q.delete();
    exp_fetch = 32'h0;
    first_pending = 0;
    @(posedge clk); #2;
    rst = 0;
    cycle(0, 0, 1, 100, 1, 1, 1);
    repeat (20) cycle(0, 0, 1, 100, 1, 1, 0);

    // drain everything still outstanding
    repeat (30) cycle(0, 0, 1, 0, 1, 1, 0);
    check("drain_empty", exp_q.size(), 0);
    check("drain_inflight", inflight.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
